// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - handshake/bus bundle between the sequencer and the control/datapath
// Signals: run/step/halt_req control, decoded instruction fields, memory ready handshakes,
//          architectural write strobes, state/status and the retired-instruction count.
// Modports: master = sequencer side (drives strobes/status), slave = surrounding core/memories.
interface cpu_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic             step;
    logic             halt_req;
    logic [5:0]       op_code;
    logic             reg_write;
    logic             mem_write;
    logic [1:0]       mem_to_reg;
    logic             imem_ready;
    logic             dmem_ready;
    logic             ir_load;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             rf_we;
    logic             flag_we;
    logic             pc_load;
    logic [2:0]       state;
    logic             busy;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, step, halt_req, op_code, reg_write, mem_write, mem_to_reg,
               imem_ready, dmem_ready,
        output ir_load, imem_req, dmem_req, dmem_we, rf_we, flag_we, pc_load,
               state, busy, halted, fault, retired
    );

    modport slave (
        output run, step, halt_req, op_code, reg_write, mem_write, mem_to_reg,
               imem_ready, dmem_ready,
        input  ir_load, imem_req, dmem_req, dmem_we, rf_we, flag_we, pc_load,
               state, busy, halted, fault, retired
    );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer gating architectural writes
// Ports: clk (rising edge), rst_n (async active-low),
//        bus (cpu_sequencer_if.master): run/step/halt_req, op_code/reg_write/mem_write/mem_to_reg,
//        imem_ready/dmem_ready in; ir_load/imem_req/dmem_req/dmem_we/rf_we/flag_we/pc_load,
//        state/busy/halted/fault/retired out.
module cpu_sequencer #(
    parameter logic [5:0] HALT_OPC   = 6'd63,
    parameter int         WAIT_LIMIT = 16,
    parameter int         CNT_W      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    cpu_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Last wait cycle tolerated before the watchdog trips.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    state_t           state_q, state_n;
    logic [7:0]       wait_q, wait_n;
    logic             one_shot_q, one_shot_n;
    logic             fault_q, fault_n;
    logic             retire;

    logic             dec_load_q, dec_store_q, dec_rw_q;

    logic             imem_req_q, dmem_req_q, dmem_we_q, rf_we_q, flag_we_q, pc_load_q;
    logic             busy_q, halted_q;
    logic [CNT_W-1:0] retired_q;

    // Live decode, only meaningful while in DECODE (captured into dec_*_q there).
    logic live_load, live_store, live_alu, exec_retires;
    assign live_load    = (bus.mem_to_reg == 2'b01);
    assign live_store   = bus.mem_write;
    assign live_alu     = (bus.op_code == 6'd32) || (bus.op_code == 6'd0) || (bus.op_code == 6'd1);
    assign exec_retires = !live_load && !live_store && !bus.reg_write;

    always_comb begin
        state_n    = state_q;
        wait_n     = '0;
        one_shot_n = one_shot_q;
        fault_n    = fault_q;
        retire     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_n    = S_FETCH;
                    one_shot_n = 1'b0;
                end else if (bus.step) begin
                    state_n    = S_FETCH;
                    one_shot_n = 1'b1;
                end
            end
            S_FETCH: begin
                if (bus.imem_ready) begin
                    state_n = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_n = S_HALT;
                    fault_n = 1'b1;
                end else begin
                    wait_n = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                state_n = (bus.op_code == HALT_OPC) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (dec_load_q || dec_store_q) begin
                    state_n = S_MEM;
                end else if (dec_rw_q) begin
                    state_n = S_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                if (bus.dmem_ready) begin
                    if (dec_load_q) begin
                        state_n = S_WB;
                    end else begin
                        retire = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_n = S_HALT;
                    fault_n = 1'b1;
                end else begin
                    wait_n = wait_q + 8'd1;
                end
            end
            S_WB: begin
                retire = 1'b1;
            end
            S_HALT: begin
                state_n = S_HALT;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // halt_req and run only matter at the instruction boundary; a step-launched
        // instruction always returns to IDLE.
        if (retire) begin
            state_n    = (bus.run && !bus.halt_req && !one_shot_q) ? S_FETCH : S_IDLE;
            one_shot_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            one_shot_q  <= 1'b0;
            fault_q     <= 1'b0;
            dec_load_q  <= 1'b0;
            dec_store_q <= 1'b0;
            dec_rw_q    <= 1'b0;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            rf_we_q     <= 1'b0;
            flag_we_q   <= 1'b0;
            pc_load_q   <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q    <= state_n;
            wait_q     <= wait_n;
            one_shot_q <= one_shot_n;
            fault_q    <= fault_n;
            if (state_q == S_DECODE) begin
                dec_load_q  <= live_load;
                dec_store_q <= live_store;
                dec_rw_q    <= bus.reg_write;
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            // Outputs are decoded from the next state so they line up with state_q.
            // EXEC is only entered from DECODE, so its strobes use the live decode.
            imem_req_q <= (state_n == S_FETCH);
            dmem_req_q <= (state_n == S_MEM);
            dmem_we_q  <= (state_n == S_MEM) && dec_store_q;
            rf_we_q    <= (state_n == S_WB);
            flag_we_q  <= (state_n == S_EXEC) && live_alu;
            pc_load_q  <= (state_n == S_WB) || ((state_n == S_EXEC) && exec_retires);
            busy_q     <= (state_n != S_IDLE) && (state_n != S_HALT);
            halted_q   <= (state_n == S_HALT);
        end
    end

    // IR load and the store's PC update must land in the cycle the memory signals
    // ready, which cannot be known a cycle ahead, so they are qualified by ready here.
    assign bus.ir_load  = (state_q == S_FETCH) && bus.imem_ready;
    assign bus.pc_load  = pc_load_q || ((state_q == S_MEM) && bus.dmem_ready && !dec_load_q);
    assign bus.imem_req = imem_req_q;
    assign bus.dmem_req = dmem_req_q;
    assign bus.dmem_we  = dmem_we_q;
    assign bus.rf_we    = rf_we_q;
    assign bus.flag_we  = flag_we_q;
    assign bus.state    = state_q;
    assign bus.busy     = busy_q;
    assign bus.halted   = halted_q;
    assign bus.fault    = fault_q;
    assign bus.retired  = retired_q;
endmodule
